// File: rtl/alpha_scan_ctrl.sv
// Multiplexed 14-segment alphanumeric scan controller with a writable message buffer.
// Optional macro SCROLL_EN enables message scrolling every SCROLL_DIV frames.
module alpha_scan_ctrl #(
   parameter int DIGITS     = 4,
   parameter int MSG_LEN    = 16,
   parameter int SCAN_DIV   = 1000,
   parameter int SCROLL_DIV = 50
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       wr_en,
   input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
   input  logic [4:0]                 wr_data,
   output logic [4:0]                 code,
   output logic [DIGITS-1:0]          dig_sel,
   output logic                       frame_pulse
);
   localparam int AW = $clog2(MSG_LEN);
   localparam int IW = $clog2(DIGITS);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   state_t            state;
   logic [IW-1:0]     idx;
   logic [DW-1:0]     div;
   logic [4:0]        msg [MSG_LEN];
   logic [AW-1:0]     offset;
   logic [AW-1:0]     rd_addr;
   logic              drive_end;
   logic              last_digit;
   logic              fp_next;
   logic [DIGITS-1:0] one;

   assign one        = {{(DIGITS-1){1'b0}}, 1'b1};
   assign rd_addr    = offset + AW'(idx);
   assign drive_end  = (state == DRIVE) && (div == DW'(SCAN_DIV-1));
   assign last_digit = (idx == IW'(DIGITS-1));
   // Registered pulse must land on the final DRIVE cycle, so it is armed one cycle early.
   assign fp_next    = last_digit &&
                       (((state == BLANK) && (SCAN_DIV == 1)) ||
                        ((state == DRIVE) && (32'(div) + 2 == SCAN_DIV)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MSG_LEN; i++) msg[i] <= '0;
      end else if (wr_en) begin
         msg[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         div         <= '0;
         code        <= '0;
         dig_sel     <= '0;
         frame_pulse <= 1'b0;
      end else if (!enable) begin
         state       <= IDLE;
         idx         <= '0;
         div         <= '0;
         dig_sel     <= '0;
         frame_pulse <= 1'b0;
      end else begin
         frame_pulse <= fp_next;
         case (state)
            IDLE: state <= BLANK;
            BLANK: begin
               code    <= msg[rd_addr];
               div     <= '0;
               dig_sel <= one << idx;
               state   <= DRIVE;
            end
            DRIVE: begin
               code <= msg[rd_addr];
               if (drive_end) begin
                  dig_sel <= '0;
                  div     <= '0;
                  idx     <= last_digit ? '0 : idx + 1'b1;
                  state   <= BLANK;
               end else begin
                  div <= div + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SCROLL_EN
   localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   logic [SW-1:0] scroll_cnt;

   // Offset steps on the frame-ending edge, so the next BLANK (idx=0) already sees it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         offset     <= '0;
         scroll_cnt <= '0;
      end else if (enable && drive_end && last_digit) begin
         if (scroll_cnt == SW'(SCROLL_DIV-1)) begin
            scroll_cnt <= '0;
            offset     <= offset + 1'b1;
         end else begin
            scroll_cnt <= scroll_cnt + 1'b1;
         end
      end
   end
`else
   assign offset = '0;
`endif

endmodule

// File: tb/tb_alpha_scan_ctrl.sv
// Directed self-checking bench for alpha_scan_ctrl (DIGITS=4, MSG_LEN=8, SCAN_DIV=4, SCROLL_DIV=2).
module tb_alpha_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [4:0] wr_data = '0;
   logic [4:0] code;
   logic [3:0] dig_sel;
   logic       frame_pulse;

   int total = 0;
   int bad = 0;
   bit mon_on = 1'b0;

   alpha_scan_ctrl #(.DIGITS(4), .MSG_LEN(8), .SCAN_DIV(4), .SCROLL_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .code(code), .dig_sel(dig_sel), .frame_pulse(frame_pulse)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_on) begin
         total++;
         if (!$onehot0(dig_sel)) begin
            bad++;
            $display("FAIL onehot0 dig_sel=%b", dig_sel);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [4:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0;
      tick(); tick();
      mon_on = 1'b1;
      total++; if (code !== 5'd0)      begin bad++; $display("FAIL reset_code got=%0d exp=0", code); end
      total++; if (dig_sel !== 4'b0)   begin bad++; $display("FAIL reset_sel got=%b exp=0000", dig_sel); end
      total++; if (frame_pulse !== 0)  begin bad++; $display("FAIL reset_fp got=%b exp=0", frame_pulse); end
      rst_n = 1'b1;
      tick();
   endtask

   // Cycle c (1-based after enable): c%5==1 is BLANK, else digit (c-1)/5 driven; pulse at c=20.
   task automatic test_scan();
      logic [3:0] exp_sel;
      for (int i = 0; i < 4; i++) wr(3'(i), 5'(i + 1));
      enable = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         tick();
         exp_sel = (((c-1) % 5) == 0) ? 4'b0000 : (4'b0001 << (((c-1) / 5) % 4));
         total++;
         if (dig_sel !== exp_sel) begin bad++; $display("FAIL scan_sel c=%0d got=%b exp=%b", c, dig_sel, exp_sel); end
         total++;
         if (frame_pulse !== (c == 20)) begin bad++; $display("FAIL scan_fp c=%0d got=%b exp=%b", c, frame_pulse, c == 20); end
         if (exp_sel != 0) begin
            total++;
            if (code !== 5'((((c-1) / 5) % 4) + 1)) begin
               bad++; $display("FAIL scan_code c=%0d got=%0d exp=%0d", c, code, (((c-1) / 5) % 4) + 1);
            end
         end
      end
   endtask

   task automatic test_disable();
      enable = 1'b0; tick(); tick();
      enable = 1'b1;
      for (int c = 1; c <= 13; c++) tick();
      total++; if (dig_sel !== 4'b0100) begin bad++; $display("FAIL dis_pre got=%b exp=0100", dig_sel); end
      enable = 1'b0;
      tick();
      total++; if (dig_sel !== 4'b0000) begin bad++; $display("FAIL dis_sel got=%b exp=0000", dig_sel); end
      total++; if (code !== 5'd3)       begin bad++; $display("FAIL dis_code_held got=%0d exp=3", code); end
      tick();
      total++; if (dig_sel !== 4'b0000) begin bad++; $display("FAIL dis_idle got=%b exp=0000", dig_sel); end
      enable = 1'b1;
      tick();
      total++; if (dig_sel !== 4'b0000) begin bad++; $display("FAIL dis_blank got=%b exp=0000", dig_sel); end
      tick();
      total++; if (dig_sel !== 4'b0001 || code !== 5'd1) begin
         bad++; $display("FAIL dis_restart sel=%b code=%0d exp 0001/1", dig_sel, code);
      end
   endtask

   // Dropping enable on the cycle that arms the frame pulse must suppress it.
   task automatic test_frame_abort();
      enable = 1'b0; tick();
      enable = 1'b1;
      for (int c = 1; c <= 19; c++) tick();
      enable = 1'b0;
      tick();
      total++; if (frame_pulse !== 1'b0 || dig_sel !== 4'b0) begin
         bad++; $display("FAIL abort_fp fp=%b sel=%b exp 0/0000", frame_pulse, dig_sel);
      end
   endtask

   task automatic test_write_drive();
      enable = 1'b0; tick();
      enable = 1'b1;
      for (int c = 1; c <= 7; c++) tick();
      total++; if (dig_sel !== 4'b0010 || code !== 5'd2) begin
         bad++; $display("FAIL wr_pre sel=%b code=%0d exp 0010/2", dig_sel, code);
      end
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 5'd9;
      tick();
      wr_en = 1'b0;
      total++; if (code !== 5'd2) begin bad++; $display("FAIL wr_edge_n got=%0d exp=2", code); end
      tick();
      total++; if (code !== 5'd9 || dig_sel !== 4'b0010) begin
         bad++; $display("FAIL wr_edge_n1 code=%0d sel=%b exp 9/0010", code, dig_sel);
      end
   endtask

   task automatic test_reset_mid_drive();
      rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'd31;
      tick();
      wr_en = 1'b0; rst_n = 1'b1;
      total++; if (code !== 5'd0 || dig_sel !== 4'b0 || frame_pulse !== 1'b0) begin
         bad++; $display("FAIL rstmid_out code=%0d sel=%b fp=%b exp 0/0000/0", code, dig_sel, frame_pulse);
      end
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) begin
            total++; if (dig_sel !== 4'b0) begin bad++; $display("FAIL rstmid_blank got=%b exp=0000", dig_sel); end
         end
         if (((c-1) % 5) == 1) begin
            total++;
            if (dig_sel !== (4'b0001 << ((c-1) / 5)) || code !== 5'd0) begin
               bad++; $display("FAIL rstmid_digit c=%0d sel=%b code=%0d exp code 0", c, dig_sel, code);
            end
         end
      end
      total++; if (frame_pulse !== 1'b1) begin bad++; $display("FAIL rstmid_fp got=%b exp=1", frame_pulse); end
   endtask

`ifdef SCROLL_EN
   task automatic test_scroll();
      logic [2:0] exp_code;
      rst_n = 1'b0; enable = 1'b0; tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) wr(3'(i), 5'(i));
      enable = 1'b1;
      tick();
      for (int f = 1; f <= 16; f++) begin
         for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 5; k++) begin
               tick();
               if (k == 0) begin
                  exp_code = 3'(((f-1) / 2) + d);
                  total++;
                  if (code !== {2'b00, exp_code}) begin
                     bad++; $display("FAIL scroll f=%0d d=%0d got=%0d exp=%0d", f, d, code, exp_code);
                  end
               end
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_scan();
      test_disable();
      test_frame_abort();
      test_write_drive();
      test_reset_mid_drive();
`ifdef SCROLL_EN
      test_scroll();
`endif
      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
